// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared types and constants for the decode_scan block.
//   state_t     : FSM states BLANK / DIRECT / SCAN
//   MODE_DIRECT : value of the mode input selecting direct decode
//   MODE_SCAN   : value of the mode input selecting auto-scan
//   next_state(): next-state rule, evaluated every cycle
// -----------------------------------------------------------------------------
package decode_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // The state follows enable/mode directly; there are no sticky transitions.
    function automatic state_t next_state(input logic enable, input logic mode);
        if (!enable)
            return BLANK;
        else if (mode == MODE_SCAN)
            return SCAN;
        else
            return DIRECT;
    endfunction

endpackage

// File: rtl/decode_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Dwell counter for the scan walk. Each index is held dwell+1 cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears the counter
//   clear : restart the dwell period (takes priority over run)
//   run   : count this cycle
//   dwell : extra cycles per step
//   step  : high on the cycle whose edge should advance the index
// -----------------------------------------------------------------------------
module scan_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               step
);

    logic [DWELL_W-1:0] r_cnt;
    logic               w_hit;

    // Equality only: if dwell drops below the running count, the counter rolls
    // over through 2**DWELL_W and meets dwell again, so it can never stall.
    assign w_hit = (r_cnt == dwell);
    assign step  = run && !clear && w_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            if (w_hit)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/decode_scan.sv
// -----------------------------------------------------------------------------
// decode_scan
// Registered N-to-2**N one-hot decoder with a blanking state and an automatic
// scan mode that walks the index with a programmable dwell.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   enable    : 0 blanks the output
//   mode      : 0 = DIRECT, 1 = SCAN
//   in_valid  : qualifies a in DIRECT
//   a         : select index
//   dwell     : extra cycles each index is held in SCAN
//   z         : registered one-hot decode (0 when blanked)
//   idx       : index currently decoded
//   wrap      : one-cycle pulse when SCAN steps from OUT_W-1 to 0
//   dbg_state : current FSM state, for observation only
// Handshake: in_valid is a single-cycle qualifier with no ready; a code is
// taken on an edge where in_valid=1 and the next state is DIRECT, and is
// visible on z/idx right after that edge.
// -----------------------------------------------------------------------------
module decode_scan
    import decode_pkg::*;
#(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               mode,
    input  logic               in_valid,
    input  logic [N-1:0]       a,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    z,
    output logic [N-1:0]       idx,
    output logic               wrap,
    output state_t             dbg_state
);

    localparam int OUT_W = 2**N;

    state_t           r_state;
    logic [OUT_W-1:0] r_z;
    logic [N-1:0]     r_idx;
    logic             r_wrap;

    state_t           w_next;
    logic             w_scan_entry;
    logic             w_scan_run;
    logic             w_step;
    logic [N-1:0]     w_idx_inc;
    logic [OUT_W-1:0] w_hot_a;
    logic [OUT_W-1:0] w_hot_idx;
    logic [OUT_W-1:0] w_hot_inc;

    // Decisions are taken on the next state so that a mode change and an
    // in_valid on the same cycle are governed by the new mode.
    assign w_next       = next_state(enable, mode);
    assign w_scan_entry = (w_next == SCAN) && (r_state != SCAN);
    assign w_scan_run   = (w_next == SCAN) && (r_state == SCAN);

    // OUT_W is a power of two, so plain N-bit addition wraps modulo OUT_W.
    assign w_idx_inc = r_idx + N'(1);
    assign w_hot_a   = OUT_W'(1) << a;
    assign w_hot_idx = OUT_W'(1) << r_idx;
    assign w_hot_inc = OUT_W'(1) << w_idx_inc;

    scan_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_scan_entry),
        .run   (w_scan_run),
        .dwell (dwell),
        .step  (w_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BLANK;
            r_z     <= '0;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wrap  <= 1'b0;
            case (w_next)
                BLANK: begin
                    r_z <= '0;
                end
                DIRECT: begin
                    if (in_valid) begin
                        r_idx <= a;
                        r_z   <= w_hot_a;
                    end else begin
                        // Re-derived from idx so a return from BLANK restores z.
                        r_z <= w_hot_idx;
                    end
                end
                SCAN: begin
                    if (w_step) begin
                        r_idx  <= w_idx_inc;
                        r_z    <= w_hot_inc;
                        r_wrap <= &r_idx;
                    end else begin
                        r_z <= w_hot_idx;
                    end
                end
                default: begin
                    r_z <= '0;
                end
            endcase
        end
    end

    assign z         = r_z;
    assign idx       = r_idx;
    assign wrap      = r_wrap;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_decode_scan.sv
// -----------------------------------------------------------------------------
// tb_decode_scan
// Directed bench for decode_scan with N=2, DWELL_W=8.
// -----------------------------------------------------------------------------
module tb_decode_scan;
    import decode_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic       in_valid;
    logic [1:0] a;
    logic [7:0] dwell;
    logic [3:0] z;
    logic [1:0] idx;
    logic       wrap;
    state_t     dbg_state;

    int n_assert;
    int n_fail;

    decode_scan #(
        .N       (2),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .in_valid  (in_valid),
        .a         (a),
        .dwell     (dwell),
        .z         (z),
        .idx       (idx),
        .wrap      (wrap),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zw(input string tag, input logic [3:0] exp_z, input logic exp_w);
        chk({tag, "_z"}, 32'(z), 32'(exp_z));
        chk({tag, "_wrap"}, 32'(wrap), 32'(exp_w));
    endtask

    logic [3:0] exp_direct [4];
    logic [3:0] exp_scan2  [13];
    logic [3:0] exp_scan0  [6];

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        exp_direct = '{4'h1, 4'h2, 4'h4, 4'h8};
        exp_scan2  = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4,
                       4'h8, 4'h8, 4'h8, 4'h1};
        exp_scan0  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

        // Reset
        rst_n = 1'b0; enable = 1'b0; mode = MODE_DIRECT; in_valid = 1'b0;
        a = 2'd0; dwell = 8'd0;
        #2;
        tick(); tick();
        chk("rst_z", 32'(z), 32'h0);
        chk("rst_idx", 32'(idx), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(BLANK));

        // Direct decode of every code
        rst_n = 1'b1; enable = 1'b1; mode = MODE_DIRECT;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 2'(i);
            tick();
            chk($sformatf("direct_%0d", i), 32'(z), 32'(exp_direct[i]));
            chk($sformatf("direct_idx_%0d", i), 32'(idx), i);
        end

        // Hold then blank then restore
        a = 2'd2; in_valid = 1'b1;
        tick();
        chk("hold_load", 32'(z), 32'h4);
        in_valid = 1'b0; a = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_%0d", i), 32'(z), 32'h4);
        end
        enable = 1'b0; in_valid = 1'b1; a = 2'd3;
        tick();
        chk("blank_z", 32'(z), 32'h0);
        chk("blank_idx", 32'(idx), 32'h2);
        chk("blank_state", 32'(dbg_state), 32'(BLANK));
        enable = 1'b1; in_valid = 1'b0;
        tick();
        chk("unblank_z", 32'(z), 32'h4);

        // Scan with dwell=2 from idx=0
        in_valid = 1'b1; a = 2'd0;
        tick();
        chk("scan2_prep", 32'(z), 32'h1);
        in_valid = 1'b0; dwell = 8'd2; mode = MODE_SCAN;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk_zw($sformatf("scan2_%0d", i), exp_scan2[i], (i == 12));
        end
        tick();
        chk_zw("scan2_after", 4'h1, 1'b0);

        // Scan with dwell=0, entered fresh from DIRECT
        mode = MODE_DIRECT;
        tick();
        chk("scan0_prep", 32'(z), 32'h1);
        dwell = 8'd0; mode = MODE_SCAN;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_zw($sformatf("scan0_%0d", i), exp_scan0[i], (i == 4));
        end
        tick();
        chk("scan0_6", 32'(z), 32'h4);

        // Mode/valid collisions
        mode = MODE_DIRECT; in_valid = 1'b1; a = 2'd3;
        tick();
        chk_zw("coll_to_direct", 4'h8, 1'b0);
        mode = MODE_SCAN; in_valid = 1'b1; a = 2'd1;
        tick();
        chk("coll_to_scan_z", 32'(z), 32'h8);
        chk("coll_to_scan_idx", 32'(idx), 32'h3);
        in_valid = 1'b0;
        tick();
        chk_zw("coll_scan_step", 4'h1, 1'b1);

        // Mid-scan reset at idx=2
        tick();
        chk("pre_rst_1", 32'(z), 32'h2);
        tick();
        chk("pre_rst_2", 32'(idx), 32'h2);
        rst_n = 1'b0;
        tick();
        chk_zw("midrst", 4'h0, 1'b0);
        chk("midrst_idx", 32'(idx), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("postrst_0", 32'(z), 32'h1);
        tick();
        chk("postrst_1", 32'(z), 32'h2);

        // Dwell lowered below the running count: step lands after rollover
        mode = MODE_DIRECT;
        tick();
        chk("roll_prep", 32'(z), 32'h2);
        dwell = 8'd5; mode = MODE_SCAN;
        for (int i = 0; i < 5; i++) tick();
        chk("roll_before", 32'(z), 32'h2);
        dwell = 8'd1;
        for (int i = 0; i < 253; i++) tick();
        chk("roll_held", 32'(z), 32'h2);
        tick();
        chk("roll_step", 32'(z), 32'h4);
        tick();
        chk("roll_dw1_a", 32'(z), 32'h4);
        tick();
        chk("roll_dw1_b", 32'(z), 32'h8);

        // One-cycle blank inside SCAN restores z on return
        enable = 1'b0;
        tick();
        chk("scan_blank", 32'(z), 32'h0);
        enable = 1'b1;
        tick();
        chk("scan_unblank", 32'(z), 32'h8);
        chk("scan_unblank_state", 32'(dbg_state), 32'(SCAN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
